exc_commit_ctrl: RTL
====================

Name: exc_commit_ctrl

Overview:
- Exception/return sequencer between the WB stage and the CSR unit.
- Prioritises one exception cause per committing instruction and drives the CSR exception-entry signals (wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_badv) and ertn_flush.
- Issues a held flush/redirect request to Pre-IF and blocks further commits until the pipeline has drained.

Parameters:
- DRAIN_CYCLES, 2: post-ack cycles during which commits stay blocked; legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- wb_valid  in  1  instruction present in WB this cycle
- wb_pc_in  in  32  PC of WB instruction
- wb_vaddr  in  32  faulting address (ALE: data vaddr; ADEF: PC)
- wb_exc  in  5  cause flags [0]ADEF [1]INE [2]SYS [3]BRK [4]ALE
- wb_ertn  in  1  WB instruction is ERTN
- has_int  in  1  pending enabled interrupt from CSR
- ex_entry  in  32  EENTRY value
- er_entry  in  32  ERA value
- commit_kill  out  1  combinational; suppress regfile/CSR write of WB instruction this cycle
- wb_ex  out  1  one-cycle exception-entry pulse to CSR
- wb_ecode  out  6  Ecode to CSR
- wb_esubcode  out  9  EsubCode to CSR
- wb_pc  out  32  ERA value to CSR
- wb_badv  out  32  BADV value; wb_badv_we qualifies it
- wb_badv_we  out  1  pulse with wb_ex for ADEF/ALE
- ertn_flush  out  1  one-cycle ERTN pulse to CSR
- flush_req  out  1  flush/redirect request to Pre-IF, held until acked
- flush_pc  out  32  redirect target, stable while flush_req=1
- flush_ack  in  1  Pre-IF accepted redirect
- busy  out  1  controller not in IDLE

Behaviour:
- States: IDLE, FLUSH, DRAIN. Reset → IDLE, all outputs 0, drain counter 0.
- Accept in IDLE at cycle T when wb_valid & (has_int | |wb_exc | wb_ertn).
- Priority at acceptance, highest first:
  - INT: ecode 0x00
  - ADEF: 0x08, subcode 0, badv=wb_vaddr
  - INE: 0x0D
  - SYS: 0x0B
  - BRK: 0x0C
  - ALE: 0x09, badv=wb_vaddr
  - ERTN, only when no interrupt or exception is present.
- Esubcode is always 0.
- Cycle T:
  - commit_kill=1 for exceptions and interrupts.
  - commit_kill=0 for ERTN, which retires.
- Cycle T+1, registered:
  - Exception: wb_ex=1 for one cycle, wb_pc=wb_pc_in(T), flush_pc=ex_entry(T).
  - ERTN: ertn_flush=1 for one cycle, flush_pc=er_entry(T).
  - flush_req=1 and state FLUSH in both cases.
- FLUSH: flush_req and flush_pc held. flush_ack while flush_req=1 → DRAIN next cycle, counter loaded with DRAIN_CYCLES, flush_req deasserts next cycle. flush_ack on the first FLUSH cycle is legal.
- DRAIN: counter decrements each cycle. At 1 → IDLE next cycle. No early exit.
- busy=1 in FLUSH and DRAIN.
- commit_kill=wb_valid in every non-IDLE cycle. Any exceptions or ERTN arriving then are discarded, never queued.
- flush_ack in IDLE or DRAIN is ignored.
- has_int with wb_valid=0 is not taken; interrupts attach only to a valid WB instruction.
- reset in any state → IDLE next edge with outputs cleared, including mid-FLUSH with flush_req dropped.
- All 32-bit values are passed through unmodified; no arithmetic beyond the 4-bit drain counter.

Decomposition:
- Shared package (csr_pkg): Ecode constants ECODE_INT/ADEF/ALE/SYS/BRK/INE, the wb_exc bit indices, and the state enum.
- One sub-module, exc_prio_enc: combinational priority encoder from {has_int, wb_exc, wb_ertn} to {take, is_ertn, ecode, badv_we}.
- Everything else stays in the top module.

Test Plan:
- SYS at wb_pc_in=0x1c000100, ex_entry=0x1c008000; flush_ack two cycles after flush_req → commit_kill=1 at T. At T+1: wb_ex=1, ecode=0x0B, wb_pc=0x1c000100, flush_pc=0x1c008000. flush_req stays high until ack; busy for 2+DRAIN_CYCLES further cycles.
- ADEF|ALE together, wb_vaddr=0x1c000102 → ecode=0x08, wb_badv=0x1c000102, wb_badv_we=1. ALE alone → ecode=0x09 with badv.
- has_int=1 with wb_exc=BRK → ecode=0x00, not 0x0C. has_int=1 with wb_valid=0 → nothing.
- ERTN, er_entry=0x1c000200 → commit_kill=0 at T; ertn_flush=1 at T+1; flush_pc=0x1c000200; wb_ex=0.
- Back-to-back INE instructions every cycle → only the first taken. Later ones killed with no second wb_ex until IDLE is reached.
- reset asserted during FLUSH → next cycle flush_req=0, busy=0. Then the same-cycle case: flush_ack on first FLUSH cycle → DRAIN entered next cycle.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared exception codes, WB cause-flag bit positions and commit-controller states.
package csr_pkg;

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_BRK  = 6'h0C;
  localparam logic [5:0] ECODE_INE  = 6'h0D;

  localparam int EXC_ADEF = 0;
  localparam int EXC_INE  = 1;
  localparam int EXC_SYS  = 2;
  localparam int EXC_BRK  = 3;
  localparam int EXC_ALE  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/exc_prio_enc.sv
// Picks the single cause to report for a committing instruction.
module exc_prio_enc
  import csr_pkg::*;
(
  input  logic       has_int,
  input  logic [4:0] wb_exc,
  input  logic       wb_ertn,
  output logic       take,
  output logic       is_ertn,
  output logic [5:0] ecode,
  output logic       badv_we
);

  always_comb begin
    take    = has_int | (|wb_exc) | wb_ertn;
    is_ertn = 1'b0;
    ecode   = ECODE_INT;
    badv_we = 1'b0;
    if (has_int) begin
      ecode = ECODE_INT;
    end else if (wb_exc[EXC_ADEF]) begin
      ecode   = ECODE_ADEF;
      badv_we = 1'b1;
    end else if (wb_exc[EXC_INE]) begin
      ecode = ECODE_INE;
    end else if (wb_exc[EXC_SYS]) begin
      ecode = ECODE_SYS;
    end else if (wb_exc[EXC_BRK]) begin
      ecode = ECODE_BRK;
    end else if (wb_exc[EXC_ALE]) begin
      ecode   = ECODE_ALE;
      badv_we = 1'b1;
    end else if (wb_ertn) begin
      // ERTN only redirects when nothing else is pending
      is_ertn = 1'b1;
    end
  end

endmodule

// File: rtl/exc_commit_ctrl.sv
// WB-stage exception/ERTN sequencer: CSR entry pulses, held Pre-IF redirect, post-ack drain.
module exc_commit_ctrl
  import csr_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [31:0] wb_pc_in,
  input  logic [31:0] wb_vaddr,
  input  logic [4:0]  wb_exc,
  input  logic        wb_ertn,
  input  logic        has_int,
  input  logic [31:0] ex_entry,
  input  logic [31:0] er_entry,
  output logic        commit_kill,
  output logic        wb_ex,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_badv,
  output logic        wb_badv_we,
  output logic        ertn_flush,
  output logic        flush_req,
  output logic [31:0] flush_pc,
  input  logic        flush_ack,
  output logic        busy
);

  localparam logic [3:0] DRAIN_LD = 4'(DRAIN_CYCLES);

  state_t     state_q, state_d;
  logic [3:0] cnt_q;
  logic       take, is_ertn, badv_we;
  logic [5:0] ecode;
  logic       accept;

  exc_prio_enc u_prio (
    .has_int (has_int),
    .wb_exc  (wb_exc),
    .wb_ertn (wb_ertn),
    .take    (take),
    .is_ertn (is_ertn),
    .ecode   (ecode),
    .badv_we (badv_we)
  );

  assign accept      = (state_q == ST_IDLE) & wb_valid & take;
  assign busy        = (state_q != ST_IDLE);
  // While busy every WB instruction is dropped; nothing is queued behind the redirect
  assign commit_kill = busy ? wb_valid : (accept & ~is_ertn);
  assign wb_esubcode = 9'd0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept)          state_d = ST_FLUSH;
      ST_FLUSH: if (flush_ack)       state_d = ST_DRAIN;
      ST_DRAIN: if (cnt_q == 4'd1)   state_d = ST_IDLE;
      default:                       state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= 4'd0;
      wb_ex      <= 1'b0;
      wb_ecode   <= 6'd0;
      wb_pc      <= 32'd0;
      wb_badv    <= 32'd0;
      wb_badv_we <= 1'b0;
      ertn_flush <= 1'b0;
      flush_req  <= 1'b0;
      flush_pc   <= 32'd0;
    end else begin
      wb_ex      <= 1'b0;
      wb_badv_we <= 1'b0;
      ertn_flush <= 1'b0;
      if (accept) begin
        flush_req <= 1'b1;
        if (is_ertn) begin
          ertn_flush <= 1'b1;
          flush_pc   <= er_entry;
        end else begin
          wb_ex      <= 1'b1;
          wb_ecode   <= ecode;
          wb_pc      <= wb_pc_in;
          wb_badv_we <= badv_we;
          wb_badv    <= badv_we ? wb_vaddr : 32'd0;
          flush_pc   <= ex_entry;
        end
      end
      if (state_q == ST_FLUSH && flush_ack) begin
        flush_req <= 1'b0;
        cnt_q     <= DRAIN_LD;
      end else if (state_q == ST_DRAIN) begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

endmodule
